// File: rtl/rotary_quadrature_frontend.sv
// Rotary encoder front end: 2-flop sync, per-channel debounce, startup arming, A-rise quadrature decode.
// Optional wrapping position counter output `rot` is enabled with `define ROTARY_POS_COUNTER_EN.
module rotary_quadrature_frontend #(
    parameter int DB_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw,
    input  logic       dt,
    output logic       step,
    output logic       dir,
    output logic       err
`ifdef ROTARY_POS_COUNTER_EN
    ,
    output logic [7:0] rot
`endif
);

    localparam int CW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int SUW = $clog2(DB_CYCLES + 3);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [SUW-1:0] SU_MAX  = SUW'(DB_CYCLES + 1);

    // Channel bit 1 is sensor A (sw), bit 0 is sensor B (dt).
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    db;
    logic [1:0]    db_nxt;
    logic [1:0]    prev;
    logic [CW-1:0] cnt     [2];
    logic [CW-1:0] cnt_nxt [2];
    logic          armed;
    logic [SUW-1:0] su_cnt;
    logic          step_nxt;
    logic          err_nxt;
    logic          dir_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
        end else begin
            s1 <= {sw, dt};
            s2 <= s1;
        end
    end

    always_comb begin
        db_nxt = db;
        for (int i = 0; i < 2; i++) begin
            cnt_nxt[i] = cnt[i];
            if (s2[i] == db[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                db_nxt[i]  = s2[i];
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
    end

    // Until armed, the debounced levels track the synchronizer so resting levels never look like motion.
    always_ff @(posedge clk) begin
        if (rst) begin
            db     <= 2'b00;
            prev   <= 2'b00;
            armed  <= 1'b0;
            su_cnt <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else if (!armed) begin
            db   <= s2;
            prev <= s2;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
            if (su_cnt == SU_MAX) armed <= 1'b1;
            else                  su_cnt <= su_cnt + 1'b1;
        end else begin
            db   <= db_nxt;
            prev <= db;
            for (int i = 0; i < 2; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    // step and err are single-cycle strobes with no back-pressure: a consumer must sample every cycle.
    always_comb begin
        step_nxt = 1'b0;
        err_nxt  = 1'b0;
        dir_nxt  = dir;
        if (armed) begin
            if ((prev ^ db) == 2'b11) begin
                err_nxt = 1'b1;
            end else if (!prev[1] && db[1]) begin
                step_nxt = 1'b1;
                dir_nxt  = ~db[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step <= 1'b0;
            err  <= 1'b0;
            dir  <= 1'b0;
        end else begin
            step <= step_nxt;
            err  <= err_nxt;
            dir  <= dir_nxt;
        end
    end

`ifdef ROTARY_POS_COUNTER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rot <= 8'd0;
        end else if (step_nxt) begin
            rot <= dir_nxt ? rot + 8'd1 : rot - 8'd1;
        end
    end
`endif

endmodule
